// File: rtl/nios_system_mem_pkg.sv
// rtl/nios_system_mem_pkg.sv - shared types and helpers for the burst memory
package nios_system_mem_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } state_e;

    localparam int unsigned READ_LATENCY_MAX = 2;

    function automatic bit read_latency_legal(input int unsigned lat);
        return (lat >= 1) && (lat <= READ_LATENCY_MAX);
    endfunction

    function automatic int unsigned bytes_per_word(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/nios_system_mem_ram.sv
// rtl/nios_system_mem_ram.sv - single-port byte-enabled RAM with clock enable
module nios_system_mem_ram
    import nios_system_mem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 76800,
    parameter int ADDR_W    = 17,
    parameter     INIT_FILE = ""
) (
    input  logic                               clk,
    input  logic                               en,
    input  logic                               we,
    input  logic [ADDR_W-1:0]                  addr,
    input  logic [bytes_per_word(DATA_W)-1:0]  be,
    input  logic [DATA_W-1:0]                  wdata,
    output logic [DATA_W-1:0]                  rdata
`ifdef MEM_PARITY_EN
    ,
    output logic [bytes_per_word(DATA_W)-1:0]  rpar
`endif
);

    localparam int NB = bytes_per_word(DATA_W);

    logic [DATA_W-1:0] mem [DEPTH];
`ifdef MEM_PARITY_EN
    logic [NB-1:0]     par_mem [DEPTH];
`endif

    always @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < NB; b++) begin
                    if (be[b]) begin
                        mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
`ifdef MEM_PARITY_EN
                        par_mem[addr][b] <= ^wdata[b*8 +: 8];
`endif
                    end
                end
            end
            rdata <= mem[addr];
`ifdef MEM_PARITY_EN
            rpar  <= par_mem[addr];
`endif
        end
    end

endmodule

// File: rtl/nios_system_burst_memory.sv
// rtl/nios_system_burst_memory.sv - Avalon-MM burst slave RAM, FSM and read latency pipe
// Optional parity checking under MEM_PARITY_EN.
module nios_system_burst_memory
    import nios_system_mem_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 76800,
    parameter int ADDR_W       = 17,
    parameter int BURST_W      = 4,
    parameter int READ_LATENCY = 1,
    parameter     INIT_FILE    = "nios_system_main_memory.hex"
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              clken,
    input  logic                              reset_req,
    input  logic                              chipselect,
    input  logic [ADDR_W-1:0]                 address,
    input  logic [BURST_W-1:0]                burstcount,
    input  logic                              read,
    input  logic                              write,
    input  logic [bytes_per_word(DATA_W)-1:0] byteenable,
    input  logic [DATA_W-1:0]                 writedata,
    output logic                              waitrequest,
    output logic [DATA_W-1:0]                 readdata,
    output logic                              readdatavalid,
    output logic                              addr_err
`ifdef MEM_PARITY_EN
    ,
    output logic                              parity_err,
    output logic [7:0]                        parity_err_cnt
`endif
);

    localparam int                NB        = bytes_per_word(DATA_W);
    localparam bit                LAT2      = read_latency_legal(READ_LATENCY) && (READ_LATENCY == 2);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [BURST_W-1:0]   left_q, left_d;
    logic                 oor_q, oor_d;
    logic                 addr_err_q, addr_err_d;
    logic                 v1_q, z1_q;

    logic                 en;
    logic                 start_oor;
    logic [BURST_W-1:0]   cmd_cnt;
    logic                 rd_issue, ram_we, issue_oor;
    logic [ADDR_W-1:0]    cur_addr, ram_addr;
    logic [DATA_W-1:0]    ram_rdata, d1;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
    endfunction

    // reset_n is folded in so nothing is accepted or written while reset is held.
    assign en        = clken & ~reset_req & reset_n;
    assign start_oor = 32'(address) >= 32'(DEPTH);
    assign cmd_cnt   = (burstcount == '0) ? BURST_W'(1) : burstcount;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        left_d      = left_q;
        oor_d       = oor_q;
        addr_err_d  = addr_err_q;
        waitrequest = 1'b1;
        cur_addr    = addr_q;
        issue_oor   = oor_q;
        rd_issue    = 1'b0;
        ram_we      = 1'b0;
        if (en) begin
            unique case (state_q)
                IDLE: begin
                    waitrequest = 1'b0;
                    cur_addr    = address;
                    issue_oor   = start_oor;
                    if (chipselect && (read || write)) begin
                        rd_issue   = read;
                        ram_we     = write & ~read & ~start_oor;
                        addr_d     = next_addr(address);
                        left_d     = cmd_cnt - BURST_W'(1);
                        oor_d      = start_oor;
                        addr_err_d = addr_err_q | start_oor;
                        if (cmd_cnt != BURST_W'(1))
                            state_d = read ? RD_BURST : WR_BURST;
                    end
                end
                RD_BURST: begin
                    rd_issue = 1'b1;
                    addr_d   = next_addr(addr_q);
                    left_d   = left_q - BURST_W'(1);
                    if (left_q == BURST_W'(1))
                        state_d = IDLE;
                end
                WR_BURST: begin
                    waitrequest = 1'b0;
                    if (chipselect && write) begin
                        ram_we = ~oor_q;
                        addr_d = next_addr(addr_q);
                        left_d = left_q - BURST_W'(1);
                        if (left_q == BURST_W'(1))
                            state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Out-of-range beats park the RAM on word 0 and are zeroed on return.
    assign ram_addr = issue_oor ? '0 : cur_addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            left_q     <= '0;
            oor_q      <= 1'b0;
            addr_err_q <= 1'b0;
            v1_q       <= 1'b0;
            z1_q       <= 1'b0;
        end else if (en) begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            left_q     <= left_d;
            oor_q      <= oor_d;
            addr_err_q <= addr_err_d;
            v1_q       <= rd_issue;
            z1_q       <= issue_oor;
        end
    end

    assign addr_err = addr_err_q;
    assign d1       = (v1_q && !z1_q) ? ram_rdata : '0;

`ifdef MEM_PARITY_EN
    logic [NB-1:0] ram_rpar, calc_par;
    logic          perr1, perr_out;
    logic [7:0]    perr_cnt_q;

    always_comb begin
        calc_par = '0;
        for (int b = 0; b < NB; b++)
            calc_par[b] = ^ram_rdata[b*8 +: 8];
    end

    assign perr1 = v1_q & ~z1_q & (|(calc_par ^ ram_rpar));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            perr_cnt_q <= '0;
        else if (perr_out && perr_cnt_q != 8'hFF)
            perr_cnt_q <= perr_cnt_q + 8'd1;
    end

    assign parity_err     = perr_out;
    assign parity_err_cnt = perr_cnt_q;
`endif

    // Outputs are qualified by en so a stalled cycle never presents a beat twice.
    if (LAT2) begin : g_lat2
        logic              v2_q;
        logic [DATA_W-1:0] rd2_q;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                v2_q  <= 1'b0;
                rd2_q <= '0;
            end else if (en) begin
                v2_q  <= v1_q;
                rd2_q <= d1;
            end
        end
        assign readdatavalid = v2_q & en;
        assign readdata      = rd2_q;
`ifdef MEM_PARITY_EN
        logic perr2_q;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
                perr2_q <= 1'b0;
            else if (en)
                perr2_q <= perr1;
        end
        assign perr_out = perr2_q & en;
`endif
    end else begin : g_lat1
        assign readdatavalid = v1_q & en;
        assign readdata      = d1;
`ifdef MEM_PARITY_EN
        assign perr_out = perr1 & en;
`endif
    end

    nios_system_mem_ram #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .en    (en),
        .we    (ram_we),
        .addr  (ram_addr),
        .be    (byteenable),
        .wdata (writedata),
        .rdata (ram_rdata)
`ifdef MEM_PARITY_EN
        ,
        .rpar  (ram_rpar)
`endif
    );

endmodule

// File: doc/nios_system_burst_memory.md
Name: nios_system_burst_memory

Overview:
Parametrised successor to the single-port on-chip main memory. An Avalon-MM slave with configurable data width and depth, pipelined reads (readdatavalid, latency 1 or 2), incrementing bursts and waitrequest back-pressure. It sits on the Nios II data master / DMA interconnect as program and packet-buffer RAM. Memory storage is an inferred synchronous RAM.

Parameters:
DATA_W, 32, data bus width in bits; multiple of 8
DEPTH, 76800, number of words
ADDR_W, 17, word address width; must satisfy 2**ADDR_W >= DEPTH
BURST_W, 4, burstcount width; maximum burst is 2**(BURST_W-1) beats
READ_LATENCY, 1, cycles from RAM address issue to readdatavalid; legal values 1 or 2
INIT_FILE, "nios_system_main_memory.hex", RAM initialisation file

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
clken  in  1  global clock enable; when low, all state holds
reset_req  in  1  when high, stalls the block like clken=0 (protects RAM during reset sequencing)
chipselect  in  1  slave select
address  in  ADDR_W  word address of the first beat
burstcount  in  BURST_W  beats in burst; 0 is treated as 1
read  in  1  read request
write  in  1  write request / write beat
byteenable  in  DATA_W/8  byte lanes for write beats
writedata  in  DATA_W  write data
waitrequest  out  1  command or beat not accepted this cycle
readdata  out  DATA_W  read data
readdatavalid  out  1  readdata valid this cycle
addr_err  out  1  sticky flag: an access targeted an address >= DEPTH; cleared only by reset

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE; waitrequest=1; readdatavalid=0; readdata=0; addr_err=0; counters=0. RAM contents are not cleared. waitrequest drops in the first enabled cycle after reset_n rises.
- Enable: en = clken & ~reset_req. When en=0, all registers hold, the RAM is not written, and waitrequest=1.
- FSM states: IDLE, RD_BURST, WR_BURST.
- IDLE:
  - chipselect&read: accepts the command (waitrequest=0 that cycle). Latches address and count, issues beat 0 to the RAM the same cycle, then goes to RD_BURST if count>1; otherwise stays in IDLE.
  - chipselect&write: first beat is written that cycle. Goes to WR_BURST if count>1.
  - read and write asserted together: read has priority; the write is ignored and waitrequest stays 0.
- RD_BURST:
  - Issues one address per enabled cycle, incrementing.
  - waitrequest=1, so new commands are held off.
  - Returns to IDLE after the last beat is issued.
  - readdatavalid pulses exactly READ_LATENCY enabled cycles after each beat issue, giving back-to-back valid for bursts.
- WR_BURST:
  - waitrequest=0.
  - Each cycle with chipselect&write writes one beat at the incrementing address, using per-beat byteenable. A cycle without write inserts no beat.
  - Returns to IDLE after the final beat.
- Address arithmetic:
  - The internal address is ADDR_W bits and wraps from DEPTH-1 to 0 within a burst.
  - A command whose start address is >= DEPTH sets addr_err. Its writes are dropped and its reads return all-zero data, with readdatavalid still issued for every beat.
- Read during write to the same address in the same cycle cannot occur: it is a single port and the FSM serialises accesses.
- Pending read beats still complete (readdatavalid) after the FSM returns to IDLE. A new read may be accepted in that cycle; data ordering is preserved by the latency pipe.
- READ_LATENCY=2 adds an output register after the RAM q.

Optional Feature:
MEM_PARITY_EN:
- Defined: one parity bit is stored per byte (even parity), updated on each byte-enabled write. Each returned beat is checked. A mismatch raises the extra output parity_err, a single-cycle pulse aligned with readdatavalid, and a saturating 8-bit parity_err_cnt output (reset 0).
- Undefined: no parity storage, and neither port exists.

Decomposition:
- Package nios_system_mem_pkg: FSM state enum (IDLE/RD_BURST/WR_BURST), a legal-READ_LATENCY check constant, and a bytes-per-word helper function.
- Sub-module nios_system_mem_ram: a behavioural single-port byte-enabled RAM with INIT_FILE load and clock enable, and optional parity lanes. The top level holds the FSM, counters and latency pipe.

Test Plan:
- Reset mid-burst: assert reset_n=0 during beat 3 of an 8-beat read -> readdatavalid=0 immediately, no further valids, and waitrequest=1 until the first enabled cycle after release.
- Write burst: count 4 at address 0x10, data 0xA0..0xA3, byteenable 0xF -> read burst of 4 returns 0xA0..0xA3 on consecutive cycles at latency 1, and again with READ_LATENCY=2.
- Byte enables: write 0x11223344 with be=0xF, then 0xFFFFFFFF with be=0x5 -> read gives 0x11FF33FF.
- Wrap: read burst of 4 at address DEPTH-2 -> data from DEPTH-2, DEPTH-1, 0, 1; addr_err stays 0. A read at address DEPTH -> data 0 and addr_err=1.
- Stall: drop clken for 3 cycles mid read-burst -> the valid sequence pauses and resumes with no lost or duplicated beats. Repeat with reset_req held high -> same result, and no RAM write occurs.
- Parity (MEM_PARITY_EN): force a flip of one stored bit via a hierarchical path -> the next read of that word gives parity_err=1 and parity_err_cnt=1.
